// File: rtl/tpu_seq_pkg.sv
// Shared types and defaults for the layer sequencer and its watchdog.
`include "accelerator_mode.svh"

package tpu_seq_pkg;

   localparam int unsigned NUM_PARAM_DEF      = 3;
   localparam int unsigned TIMEOUT_CYCLES_DEF = 30000;
   localparam int unsigned WORD_W             = 32;
   localparam int unsigned RUN_CNT_W          = 32;
   localparam int unsigned MODE_W             = 4;

   localparam int unsigned MODE_IDLE_BIT = `ACC_MODE_IDLE_BIT;
   localparam int unsigned MODE_FC_BIT   = `ACC_MODE_FC_BIT;
   localparam int unsigned MODE_CONV_BIT = `ACC_MODE_CONV_BIT;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_LOAD      = 3'd1,
      ST_LOAD_WAIT = 3'd2,
      ST_LAUNCH    = 3'd3,
      ST_RUN       = 3'd4,
      ST_DONE      = 3'd5
   } seq_state_e;

   // Single-bit mode word for a given bit position.
   function automatic logic [MODE_W-1:0] mode_onehot(input int unsigned bit_pos);
      return MODE_W'(1) << bit_pos;
   endfunction

endpackage

// File: rtl/accelerator_mode.svh
// Shared one-hot bit positions for the accelerator layer mode word.
`ifndef ACCELERATOR_MODE_SVH
`define ACCELERATOR_MODE_SVH
`define ACC_MODE_IDLE_BIT 0
`define ACC_MODE_FC_BIT   1
`define ACC_MODE_CONV_BIT 2
`endif

// File: rtl/seq_watchdog.sv
// Saturating RUN-cycle counter with a registered timeout flag.
module seq_watchdog
   import tpu_seq_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clear,
   input  logic                 enable,
   output logic [RUN_CNT_W-1:0] count,
   output logic                 expired
);

   localparam logic [RUN_CNT_W-1:0] LIMIT = RUN_CNT_W'(TIMEOUT_CYCLES - 1);

   logic [RUN_CNT_W-1:0] count_d;

   // Holds at all-ones instead of wrapping.
   always_comb begin
      count_d = count;
      if (clear) begin
         count_d = '0;
      end else if (enable && (count != '1)) begin
         count_d = count + RUN_CNT_W'(1);
      end
   end

   // expired mirrors (count == LIMIT) one register stage earlier than a compare on count.
   always_ff @(posedge clk) begin
      if (rst) begin
         count   <= '0;
         expired <= 1'b0;
      end else begin
         count   <= count_d;
         expired <= (count_d == LIMIT);
      end
   end

endmodule

// File: rtl/layer_sequencer.sv
// Per-layer controller: loads parameter words, launches the FC or CONV engine and waits for done.
module layer_sequencer
   import tpu_seq_pkg::*;
#(
   parameter int unsigned NUM_PARAM      = NUM_PARAM_DEF,
   parameter int unsigned PARAM_AW       = 2,
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             start_i,
   input  logic [MODE_W-1:0]                mode_i,
   output logic                             param_cs_o,
   output logic [PARAM_AW-1:0]              param_addr_o,
   input  logic [WORD_W-1:0]                param_rdata_i,
   output logic [NUM_PARAM-1:0][WORD_W-1:0] cfg_o,
   output logic                             fc_start_o,
   output logic                             conv_start_o,
   input  logic                             fc_done_i,
   input  logic                             conv_done_i,
   output logic                             busy_o,
   output logic                             finish_o,
   output logic                             err_o,
   output logic [RUN_CNT_W-1:0]             run_cycles_o
);

   localparam logic [PARAM_AW-1:0] LAST_ADDR = PARAM_AW'(NUM_PARAM - 1);
   localparam logic [MODE_W-1:0]   MODE_IDLE = mode_onehot(MODE_IDLE_BIT);
   localparam logic [MODE_W-1:0]   MODE_FC   = mode_onehot(MODE_FC_BIT);
   localparam logic [MODE_W-1:0]   MODE_CONV = mode_onehot(MODE_CONV_BIT);

   seq_state_e           state_q, state_d;
   logic [MODE_W-1:0]    mode_q, mode_d;
   logic [PARAM_AW-1:0]  addr_d;
   logic                 err_d;
   logic                 wd_clear, wd_enable, wd_expired;
   logic                 done_sel;
   logic                 rd_vld_q;
   logic [PARAM_AW-1:0]  rd_idx_q;

   // Only the done input of the latched engine matters.
   assign done_sel  = mode_q[MODE_FC_BIT] ? fc_done_i : conv_done_i;
   assign wd_enable = (state_q == ST_RUN);

   seq_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk    (clk),
      .rst    (rst),
      .clear  (wd_clear),
      .enable (wd_enable),
      .count  (run_cycles_o),
      .expired(wd_expired)
   );

   always_comb begin
      state_d  = state_q;
      mode_d   = mode_q;
      addr_d   = '0;
      err_d    = err_o;
      wd_clear = 1'b0;
      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start_i) begin
               mode_d   = mode_i;
               err_d    = 1'b0;
               wd_clear = 1'b1;
               if ((mode_i == MODE_FC) || (mode_i == MODE_CONV)) begin
                  state_d = ST_LOAD;
               end else begin
                  state_d = ST_DONE;
                  err_d   = (mode_i != MODE_IDLE);
               end
            end
         end
         ST_LOAD: begin
            if (param_addr_o == LAST_ADDR) begin
               state_d = ST_LOAD_WAIT;
            end else begin
               addr_d = param_addr_o + PARAM_AW'(1);
            end
         end
         ST_LOAD_WAIT: state_d = ST_LAUNCH;
         ST_LAUNCH:    state_d = ST_RUN;
         ST_RUN: begin
            // Done beats a coincident timeout.
            if (done_sel) begin
               state_d = ST_DONE;
               err_d   = 1'b0;
            end else if (wd_expired) begin
               state_d = ST_DONE;
               err_d   = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs are registered decodes of the next state so they line up with the state they describe.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         mode_q       <= '0;
         param_cs_o   <= 1'b0;
         param_addr_o <= '0;
         fc_start_o   <= 1'b0;
         conv_start_o <= 1'b0;
         busy_o       <= 1'b0;
         finish_o     <= 1'b0;
         err_o        <= 1'b0;
         rd_vld_q     <= 1'b0;
         rd_idx_q     <= '0;
         cfg_o        <= '0;
      end else begin
         state_q      <= state_d;
         mode_q       <= mode_d;
         param_cs_o   <= (state_d == ST_LOAD);
         param_addr_o <= addr_d;
         fc_start_o   <= (state_d == ST_LAUNCH) && mode_d[MODE_FC_BIT];
         conv_start_o <= (state_d == ST_LAUNCH) && mode_d[MODE_CONV_BIT];
         busy_o       <= state_d inside {ST_LOAD, ST_LOAD_WAIT, ST_LAUNCH, ST_RUN};
         finish_o     <= (state_d == ST_DONE);
         err_o        <= err_d;
         rd_vld_q     <= param_cs_o;
         rd_idx_q     <= param_addr_o;
         // Read data lags the address by one cycle.
         if (rd_vld_q) begin
            for (int k = 0; k < int'(NUM_PARAM); k++) begin
               if (rd_idx_q == PARAM_AW'(k)) begin
                  cfg_o[k] <= param_rdata_i;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench: default-timeout instance (a) and a short-timeout instance (b) share stimulus.
module tb_layer_sequencer;
   import tpu_seq_pkg::*;

   logic clk = 1'b0;
   logic rst, start, fc_done, conv_done;
   logic [3:0] mode;

   logic        cs_a, cs_b, fcs_a, fcs_b, cvs_a, cvs_b;
   logic        busy_a, busy_b, fin_a, fin_b, err_a, err_b;
   logic [1:0]  addr_a, addr_b;
   logic [31:0] rdata_a, rdata_b, run_a, run_b;
   logic [2:0][31:0] cfg_a, cfg_b;
   logic [31:0] mem [0:3];

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   layer_sequencer dut_a (
      .clk(clk), .rst(rst), .start_i(start), .mode_i(mode),
      .param_cs_o(cs_a), .param_addr_o(addr_a), .param_rdata_i(rdata_a),
      .cfg_o(cfg_a), .fc_start_o(fcs_a), .conv_start_o(cvs_a),
      .fc_done_i(fc_done), .conv_done_i(conv_done),
      .busy_o(busy_a), .finish_o(fin_a), .err_o(err_a), .run_cycles_o(run_a)
   );

   layer_sequencer #(.TIMEOUT_CYCLES(50)) dut_b (
      .clk(clk), .rst(rst), .start_i(start), .mode_i(mode),
      .param_cs_o(cs_b), .param_addr_o(addr_b), .param_rdata_i(rdata_b),
      .cfg_o(cfg_b), .fc_start_o(fcs_b), .conv_start_o(cvs_b),
      .fc_done_i(fc_done), .conv_done_i(conv_done),
      .busy_o(busy_b), .finish_o(fin_b), .err_o(err_b), .run_cycles_o(run_b)
   );

   // Synchronous parameter memory, one-cycle read latency.
   always @(posedge clk) begin
      if (cs_a) rdata_a <= mem[addr_a];
      if (cs_b) rdata_b <= mem[addr_b];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic adv(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; mode = 4'b0000; fc_done = 1'b0; conv_done = 1'b0;
      mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'hdead_beef;
      adv(2);
      chk("rst_busy", 32'(busy_a), 32'd0);
      chk("rst_finish", 32'(fin_a), 32'd0);
      chk("rst_err", 32'(err_a), 32'd0);
      chk("rst_cs", 32'(cs_a), 32'd0);
      chk("rst_run", run_a, 32'd0);
      chk("rst_cfg0", cfg_a[0], 32'd0);
      chk("rst_fcs", 32'(fcs_a), 32'd0);
      rst = 1'b0;
      adv(1);

      // FC layer, start sampled at edge T
      mode = 4'b0010; start = 1'b1;
      adv(1);                                   // T+1
      start = 1'b0;
      chk("fc_cs_t1", 32'(cs_a), 32'd1);
      chk("fc_addr_t1", 32'(addr_a), 32'd0);
      chk("fc_busy_t1", 32'(busy_a), 32'd1);
      start = 1'b1; mode = 4'b0100;             // stray start during LOAD
      adv(1);                                   // T+2
      start = 1'b0; mode = 4'b0010;
      chk("fc_addr_t2", 32'(addr_a), 32'd1);
      adv(1);                                   // T+3
      chk("fc_addr_t3", 32'(addr_a), 32'd2);
      chk("fc_cfg0_t3", cfg_a[0], 32'h11);
      adv(1);                                   // T+4
      chk("fc_cs_t4", 32'(cs_a), 32'd0);
      chk("fc_cfg1_t4", cfg_a[1], 32'h22);
      chk("fc_fcs_t4", 32'(fcs_a), 32'd0);
      adv(1);                                   // T+5
      chk("fc_fcs_t5", 32'(fcs_a), 32'd1);
      chk("fc_cvs_t5", 32'(cvs_a), 32'd0);
      chk("fc_cfg2_t5", cfg_a[2], 32'h33);
      adv(1);                                   // T+6, first RUN cycle
      chk("fc_fcs_t6", 32'(fcs_a), 32'd0);
      chk("fc_run_t6", run_a, 32'd0);
      adv(4);                                   // T+10
      start = 1'b1;                             // stray start during RUN
      adv(1);                                   // T+11
      start = 1'b0;
      chk("fc_stray_busy", 32'(busy_a), 32'd1);
      chk("fc_stray_run", run_a, 32'd5);
      adv(44);                                  // T+55
      chk("to_b_fin_t55", 32'(fin_b), 32'd0);
      chk("to_b_run_t55", run_b, 32'd49);
      adv(1);                                   // T+56
      chk("to_b_fin_t56", 32'(fin_b), 32'd1);
      chk("to_b_err_t56", 32'(err_b), 32'd1);
      chk("to_b_run_t56", run_b, 32'd50);
      chk("to_b_busy_t56", 32'(busy_b), 32'd0);
      chk("fc_a_busy_t56", 32'(busy_a), 32'd1);
      adv(49);                                  // T+105
      fc_done = 1'b1; conv_done = 1'b0;
      adv(1);                                   // T+106
      fc_done = 1'b0;
      chk("fc_fin", 32'(fin_a), 32'd1);
      chk("fc_err", 32'(err_a), 32'd0);
      chk("fc_run", run_a, 32'd100);
      chk("fc_busy_done", 32'(busy_a), 32'd0);
      chk("to_b_done_ignored_err", 32'(err_b), 32'd1);
      chk("to_b_done_ignored_run", run_b, 32'd50);
      adv(3);
      chk("fc_fin_hold", 32'(fin_a), 32'd1);

      // CONV layer back-to-back from DONE, new parameter set
      mem[0] = 32'hA1; mem[1] = 32'hB2; mem[2] = 32'hC3;
      mode = 4'b0100; start = 1'b1;
      adv(1);                                   // T'+1
      start = 1'b0;
      chk("cv_fin_clr", 32'(fin_a), 32'd0);
      chk("cv_run_clr", run_a, 32'd0);
      chk("cv_busy", 32'(busy_a), 32'd1);
      chk("cv_b_fin_clr", 32'(fin_b), 32'd0);
      adv(4);                                   // T'+5
      chk("cv_cvs_t5", 32'(cvs_a), 32'd1);
      chk("cv_fcs_t5", 32'(fcs_a), 32'd0);
      chk("cv_cfg0", cfg_a[0], 32'hA1);
      chk("cv_cfg1", cfg_a[1], 32'hB2);
      chk("cv_cfg2", cfg_a[2], 32'hC3);
      chk("cv_b_cfg2", cfg_b[2], 32'hC3);
      chk("cv_b_cvs_t5", 32'(cvs_b), 32'd1);
      adv(1);                                   // T'+6
      chk("cv_cvs_t6", 32'(cvs_a), 32'd0);
      adv(14);                                  // T'+20
      fc_done = 1'b1;                           // wrong engine
      adv(1);                                   // T'+21
      fc_done = 1'b0;
      chk("cv_fcdone_fin", 32'(fin_a), 32'd0);
      chk("cv_fcdone_busy", 32'(busy_a), 32'd1);
      chk("cv_b_fcdone_fin", 32'(fin_b), 32'd0);
      adv(34);                                  // T'+55, b shows count 49
      chk("cv_b_run_t55", run_b, 32'd49);
      conv_done = 1'b1;                         // coincident with b timeout
      adv(1);                                   // T'+56
      conv_done = 1'b0;
      chk("cv_fin", 32'(fin_a), 32'd1);
      chk("cv_err", 32'(err_a), 32'd0);
      chk("cv_run", run_a, 32'd50);
      chk("race_b_fin", 32'(fin_b), 32'd1);
      chk("race_b_err", 32'(err_b), 32'd0);
      chk("race_b_run", run_b, 32'd50);

      // Illegal mode
      mode = 4'b0110; start = 1'b1;
      adv(1);
      start = 1'b0;
      chk("ill_fin", 32'(fin_a), 32'd1);
      chk("ill_err", 32'(err_a), 32'd1);
      chk("ill_cs", 32'(cs_a), 32'd0);
      chk("ill_busy", 32'(busy_a), 32'd0);
      chk("ill_run", run_a, 32'd0);
      chk("ill_cfg_keep", cfg_a[1], 32'hB2);
      adv(1);
      chk("ill_cs_later", 32'(cs_a), 32'd0);

      // IDLE mode
      mode = 4'b0001; start = 1'b1;
      adv(1);
      start = 1'b0;
      chk("idle_fin", 32'(fin_a), 32'd1);
      chk("idle_err", 32'(err_a), 32'd0);

      // Reset during RUN, with a coincident done
      mode = 4'b0010; start = 1'b1;
      adv(1);
      start = 1'b0;
      adv(8);
      chk("rr_busy_pre", 32'(busy_a), 32'd1);
      chk("rr_run_pre", run_a, 32'd3);
      rst = 1'b1; fc_done = 1'b1;
      adv(1);
      rst = 1'b0; fc_done = 1'b0;
      chk("rr_busy", 32'(busy_a), 32'd0);
      chk("rr_fin", 32'(fin_a), 32'd0);
      chk("rr_err", 32'(err_a), 32'd0);
      chk("rr_run", run_a, 32'd0);
      chk("rr_cfg0", cfg_a[0], 32'd0);
      adv(5);
      chk("rr_fin_later", 32'(fin_a), 32'd0);
      chk("rr_busy_later", 32'(busy_a), 32'd0);

      // Reset during LOAD, with start held alongside reset
      start = 1'b1;
      adv(1);
      chk("rl_cs", 32'(cs_a), 32'd1);
      rst = 1'b1;
      adv(1);
      rst = 1'b0; start = 1'b0;
      chk("rl_busy", 32'(busy_a), 32'd0);
      chk("rl_cs_off", 32'(cs_a), 32'd0);
      for (int i = 0; i < 6; i++) begin
         adv(1);
         chk("rl_no_launch", 32'(fcs_a), 32'd0);
         chk("rl_no_busy", 32'(busy_a), 32'd0);
      end
      chk("rl_fin", 32'(fin_a), 32'd0);
      chk("rl_b_fcs", 32'(fcs_b), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/layer_sequencer.md
LAYER_SEQUENCER -- requirements
Module: layer_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; the clock port is clk and the reset port is rst.
REQ-002 The block SHALL have these parameters, one per line:
- NUM_PARAM, default 3, number of 32-bit parameter words loaded per layer.
- PARAM_AW, default 2, parameter-memory address width.
- TIMEOUT_CYCLES, default 30000, maximum RUN cycles before abort.
REQ-003 The block SHALL have these ports, one per line:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start_i  in  1  layer start request; sampled only in IDLE or DONE.
- mode_i  in  4  one-hot layer mode, using the IDLE/FC/CONV bit positions from accelerator_mode.svh.
- param_cs_o  out  1  parameter-memory read enable.
- param_addr_o  out  PARAM_AW  parameter-memory word address.
- param_rdata_i  in  32  parameter-memory read data, valid one cycle after the read.
- cfg_o  out  NUM_PARAM x 32  latched layer parameters.
- fc_start_o  out  1  one-cycle FC engine launch pulse.
- conv_start_o  out  1  one-cycle CONV engine launch pulse.
- fc_done_i  in  1  FC engine completion pulse.
- conv_done_i  in  1  CONV engine completion pulse.
- busy_o  out  1  high in LOAD, LOAD_WAIT, LAUNCH and RUN.
- finish_o  out  1  layer complete; level signal.
- err_o  out  1  illegal mode or timeout; valid while finish_o is high.
- run_cycles_o  out  32  count of RUN cycles in the last layer.

Function
REQ-004 The FSM SHALL have the states IDLE, LOAD, LOAD_WAIT, LAUNCH, RUN and DONE.
REQ-005 In IDLE or DONE with start_i=1, the FSM SHALL latch mode_i, clear finish_o, err_o and run_cycles_o, and branch as follows:
- mode_i equal to the FC bit alone, or the CONV bit alone: go to LOAD.
- mode_i equal to the IDLE bit alone: go to DONE with err_o=0.
- any other value: go to DONE with err_o=1.
REQ-006 LOAD SHALL last NUM_PARAM cycles, asserting param_cs_o=1 with param_addr_o = 0, 1, ..., NUM_PARAM-1 on consecutive cycles.
REQ-007 The block SHALL capture param_rdata_i into cfg_o[k] on the cycle after address k is presented; LOAD_WAIT (one cycle) captures the last word.
REQ-008 param_cs_o SHALL be 0 in every state other than LOAD.
REQ-009 LAUNCH SHALL last one cycle and assert exactly one of fc_start_o/conv_start_o, selected by the latched mode; for start sampled at edge T, the pulse SHALL be in cycle T+NUM_PARAM+2.
REQ-010 RUN SHALL increment run_cycles_o every cycle and watch only the done input of the latched mode; the other done input SHALL be ignored.
REQ-011 Done seen in RUN at cycle D SHALL produce state DONE and finish_o=1 from cycle D+1, with err_o=0.
REQ-012 If run_cycles_o reaches TIMEOUT_CYCLES-1 without done, the FSM SHALL go to DONE with err_o=1.
REQ-013 If done and timeout occur in the same cycle, done SHALL win and err_o SHALL be 0.
REQ-014 finish_o SHALL hold high in DONE until the next accepted start_i or reset.
REQ-015 start_i SHALL be ignored while busy_o=1.
REQ-016 Done pulses arriving outside RUN SHALL be ignored.
REQ-017 run_cycles_o SHALL saturate at all-ones; wrap-around is not permitted.
REQ-018 cfg_o SHALL retain its values until the next LOAD overwrites them.

Reset
REQ-019 On rst=1 at a clock edge, the block SHALL enter IDLE with all outputs 0, cfg_o=0 and run_cycles_o=0.
REQ-020 Reset mid-LOAD or mid-RUN SHALL abort the sequence with no start pulse and no finish_o.
REQ-021 Reset SHALL take priority over start_i and over the done inputs.

Structure
REQ-022 The state enum, the NUM_PARAM default and the TIMEOUT_CYCLES default SHALL reside in the shared package tpu_seq_pkg; mode bit positions SHALL come from accelerator_mode.svh.
REQ-023 The RUN counter, its saturation and the timeout compare SHALL be one sub-module, seq_watchdog (inputs: clear, enable; outputs: count, expired).

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- FC layer: param memory holds {0x11, 0x22, 0x33}; mode=FC; start at T -> addresses 0,1,2 in T+1..T+3; cfg_o={0x11,0x22,0x33}; fc_start_o pulse at T+5; fc_done_i 100 cycles later -> finish_o=1, err_o=0, run_cycles_o=100.
- CONV layer: conv_done_i only accepted; an fc_done_i pulse in RUN -> no effect; conv_start_o single pulse.
- Illegal mode 4'b0110 -> finish_o=1, err_o=1 one cycle after start; param_cs_o never asserted.
- Timeout with TIMEOUT_CYCLES=50 and no done -> finish_o after 50 RUN cycles, err_o=1; done coincident with the 49th count -> err_o=0.
- start_i pulses during LOAD/RUN -> ignored; rst asserted in RUN -> IDLE next cycle, all outputs 0, no finish_o.
- Back-to-back layers: start in DONE -> finish_o clears and the second layer's cfg_o replaces the first.
